// File: rtl/eth_fifo_wr_arb.sv
// Frame-atomic round-robin arbiter for the Ethernet TX FIFO write port.
// Ports: clk/rst_n; s0_*/s1_* valid-ready frame sources (sample data,
// command reply); fifo_wr_* write port; fifo_wr_full/fifo_almost_full;
// frame_done pulse, frame_src, sticky len_err.
// Optional ARB_STAT_EN adds s0_frames/s1_frames per-source frame counters.
module eth_fifo_wr_arb #(
    parameter int DATA_W    = 32,
    parameter int MAX_WORDS = 368,
    parameter int CNT_W     = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s0_valid,
    input  logic [DATA_W-1:0] s0_data,
    input  logic              s0_last,
    output logic              s0_ready,
    input  logic              s1_valid,
    input  logic [DATA_W-1:0] s1_data,
    input  logic              s1_last,
    output logic              s1_ready,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    input  logic              fifo_wr_full,
    input  logic              fifo_almost_full,
    output logic              frame_done,
    output logic              frame_src,
    output logic              len_err
`ifdef ARB_STAT_EN
    ,
    output logic [15:0]       s0_frames,
    output logic [15:0]       s1_frames
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        GAP
    } state_t;

    state_t           state_q, state_d;
    logic             grant_q, grant_d;
    logic             last_src_q, last_src_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic             frame_done_q, frame_done_d;
    logic             len_err_q, len_err_d;
    logic             sel_valid;
    logic             sel_last;
    logic             acc;
    logic             at_max;

    assign sel_valid = grant_q ? s1_valid : s0_valid;
    assign sel_last  = grant_q ? s1_last : s0_last;
    assign at_max    = (word_cnt_q == CNT_W'(MAX_WORDS - 1));

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_src_d   = last_src_q;
        word_cnt_d   = word_cnt_q;
        frame_done_d = 1'b0;
        len_err_d    = len_err_q;
        s0_ready     = 1'b0;
        s1_ready     = 1'b0;
        acc          = 1'b0;
        fifo_wr_data = grant_q ? s1_data : s0_data;
        unique case (state_q)
            IDLE: begin
                if (!fifo_almost_full && (s0_valid || s1_valid)) begin
                    // Contention goes to the source that did not finish
                    // the previous frame; a lone requester always wins.
                    grant_d    = (s0_valid && s1_valid) ? ~last_src_q
                                                        : s1_valid;
                    word_cnt_d = '0;
                    state_d    = XFER;
                end
            end
            XFER: begin
                s0_ready = ~grant_q & ~fifo_wr_full;
                s1_ready = grant_q & ~fifo_wr_full;
                acc      = sel_valid & ~fifo_wr_full;
                if (acc) begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    // An over-long frame is cut here; the rest of the
                    // source's words form a new frame at the next grant.
                    if (sel_last || at_max) begin
                        state_d      = GAP;
                        frame_done_d = 1'b1;
                        last_src_d   = grant_q;
                        if (!sel_last) begin
                            len_err_d = 1'b1;
                        end
                    end
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign fifo_wr_en = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_src_q   <= 1'b1;
            word_cnt_q   <= '0;
            frame_done_q <= 1'b0;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_src_q   <= last_src_d;
            word_cnt_q   <= word_cnt_d;
            frame_done_q <= frame_done_d;
            len_err_q    <= len_err_d;
        end
    end

    assign frame_done = frame_done_q;
    assign frame_src  = grant_q;
    assign len_err    = len_err_q;

`ifdef ARB_STAT_EN
    logic [15:0] s0_frames_q, s0_frames_d;
    logic [15:0] s1_frames_q, s1_frames_d;

    always_comb begin
        s0_frames_d = s0_frames_q;
        s1_frames_d = s1_frames_q;
        if (frame_done_d && !grant_q) begin
            s0_frames_d = s0_frames_q + 16'd1;
        end
        if (frame_done_d && grant_q) begin
            s1_frames_d = s1_frames_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_frames_q <= '0;
            s1_frames_q <= '0;
        end else begin
            s0_frames_q <= s0_frames_d;
            s1_frames_q <= s1_frames_d;
        end
    end

    assign s0_frames = s0_frames_q;
    assign s1_frames = s1_frames_q;
`endif

endmodule

// File: tb/tb_eth_fifo_wr_arb.sv
// Scoreboard bench for eth_fifo_wr_arb.
// Directed frames; expected words and frame sources queued up front.
module tb_eth_fifo_wr_arb;

    logic        clk;
    logic        rst_n;
    logic        s0_valid, s0_last, s0_ready;
    logic [31:0] s0_data;
    logic        s1_valid, s1_last, s1_ready;
    logic [31:0] s1_data;
    logic        fifo_wr_en;
    logic [31:0] fifo_wr_data;
    logic        fifo_wr_full;
    logic        fifo_almost_full;
    logic        frame_done;
    logic        frame_src;
    logic        len_err;
`ifdef ARB_STAT_EN
    logic [15:0] s0_frames, s1_frames;
`endif

    eth_fifo_wr_arb dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s0_valid         (s0_valid),
        .s0_data          (s0_data),
        .s0_last          (s0_last),
        .s0_ready         (s0_ready),
        .s1_valid         (s1_valid),
        .s1_data          (s1_data),
        .s1_last          (s1_last),
        .s1_ready         (s1_ready),
        .fifo_wr_en       (fifo_wr_en),
        .fifo_wr_data     (fifo_wr_data),
        .fifo_wr_full     (fifo_wr_full),
        .fifo_almost_full (fifo_almost_full),
        .frame_done       (frame_done),
        .frame_src        (frame_src),
        .len_err          (len_err)
`ifdef ARB_STAT_EN
        ,
        .s0_frames        (s0_frames),
        .s1_frames        (s1_frames)
`endif
    );

    int          vec = 0;
    int          errs = 0;
    int          cyc = 0;
    int          wr_total = 0;
    int          wr_cyc[$];
    logic [31:0] exp_w[$];
    logic        exp_f[$];
    logic        abort = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1ms;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        vec++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fifo_wr_full) begin
                chk("stall_quiet", {31'd0, s0_ready | s1_ready | fifo_wr_en},
                    32'd0);
            end
            if (fifo_wr_en) begin
                wr_total++;
                wr_cyc.push_back(cyc);
                if (exp_w.size() == 0) begin
                    chk("unexpected_wr", fifo_wr_data, 32'hDEAD_BEEF);
                end else begin
                    chk("wr_data", fifo_wr_data, exp_w.pop_front());
                end
            end
            if (frame_done) begin
                if (exp_f.size() == 0) begin
                    chk("unexpected_done", {31'd0, frame_src}, 32'hFFFF);
                end else begin
                    chk("frame_src", {31'd0, frame_src},
                        {31'd0, exp_f.pop_front()});
                end
            end
        end
    end

    task automatic drive(input int src, input logic v,
                         input logic [31:0] d, input logic l);
        if (src == 0) begin
            s0_valid = v; s0_data = d; s0_last = l;
        end else begin
            s1_valid = v; s1_data = d; s1_last = l;
        end
    endtask

    // Sends n words base+i; last on word index last_at (-1: never).
    task automatic send(input int src, input logic [31:0] base,
                        input int n, input int last_at);
        int t;
        logic rdy;
        for (int i = 0; i < n; i++) begin
            drive(src, 1'b1, base + 32'(i), (i == last_at));
            t = 0;
            do begin
                @(negedge clk);
                t++;
                rdy = (src == 0) ? s0_ready : s1_ready;
            end while (!rdy && !abort && t < 2000);
            if (abort) break;
            if (!rdy) begin
                chk("send_timeout", 32'(t), 32'd0);
                break;
            end
            @(posedge clk);
            #1;
        end
        drive(src, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic push_frame(input logic src, input logic [31:0] base,
                              input int n);
        for (int i = 0; i < n; i++) exp_w.push_back(base + 32'(i));
        exp_f.push_back(src);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    int c0;
    int d;

    initial begin
        rst_n = 1'b0;
        s0_valid = 0; s0_data = 0; s0_last = 0;
        s1_valid = 0; s1_data = 0; s1_last = 0;
        fifo_wr_full = 0;
        fifo_almost_full = 0;
        #12;
        chk("rst_s0_ready", {31'd0, s0_ready}, 32'd0);
        chk("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
        do_reset();
        chk("rst_s1_ready", {31'd0, s1_ready}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_frame_src", {31'd0, frame_src}, 32'd0);
        chk("rst_len_err", {31'd0, len_err}, 32'd0);

        // Single 4-word frame from s0.
        wr_cyc.delete();
        push_frame(1'b0, 32'hA000_0000, 4);
        c0 = cyc;
        send(0, 32'hA000_0000, 4, 3);
        idle(3);
        chk("t1_nwr", 32'(wr_cyc.size()), 32'd4);
        chk("t1_latency", 32'(wr_cyc[0] - c0), 32'd1);
        chk("t1_span", 32'(wr_cyc[3] - wr_cyc[0]), 32'd3);

        // Both sources from reset, alternating 3-word frames.
        do_reset();
        wr_cyc.delete();
        push_frame(1'b0, 32'hA100_0000, 3);
        push_frame(1'b1, 32'hB100_0000, 3);
        push_frame(1'b0, 32'hA200_0000, 3);
        push_frame(1'b1, 32'hB200_0000, 3);
        fork
            begin
                send(0, 32'hA100_0000, 3, 2);
                send(0, 32'hA200_0000, 3, 2);
            end
            begin
                send(1, 32'hB100_0000, 3, 2);
                send(1, 32'hB200_0000, 3, 2);
            end
        join
        idle(3);
        chk("t2_nwr", 32'(wr_cyc.size()), 32'd12);
        for (int f = 0; f < 3; f++) begin
            chk("t2_gap", 32'(wr_cyc[3*f+3] - wr_cyc[3*f+2]), 32'd3);
        end

        // fifo_wr_full for 5 cycles after the second word.
        wr_cyc.delete();
        c0 = wr_total;
        push_frame(1'b0, 32'hA300_0000, 6);
        fork
            send(0, 32'hA300_0000, 6, 5);
            begin
                do @(posedge clk); while (wr_total < c0 + 2);
                #1;
                fifo_wr_full = 1'b1;
                idle(5);
                fifo_wr_full = 1'b0;
            end
        join
        idle(3);
        chk("t3_nwr", 32'(wr_cyc.size()), 32'd6);
        chk("t3_span", 32'(wr_cyc[5] - wr_cyc[0]), 32'd10);

        // almost_full blocks grant in IDLE only.
        wr_cyc.delete();
        fifo_almost_full = 1'b1;
        push_frame(1'b1, 32'hB300_0000, 4);
        fork
            send(1, 32'hB300_0000, 4, 3);
            begin
                idle(5);
                chk("t4_af_hold", 32'(wr_cyc.size()), 32'd0);
                fifo_almost_full = 1'b0;
                d = cyc;
                idle(1);
                fifo_almost_full = 1'b1;
            end
        join
        idle(2);
        fifo_almost_full = 1'b0;
        chk("t4_grant", 32'(wr_cyc[0] - d), 32'd1);
        chk("t4_nostall", 32'(wr_cyc[3] - d), 32'd4);

        // 400 words without last until word 400: cut at 368.
        chk("t5_len_pre", {31'd0, len_err}, 32'd0);
        wr_cyc.delete();
        push_frame(1'b0, 32'hA400_0000, 368);
        push_frame(1'b0, 32'hA400_0170, 32);
        send(0, 32'hA400_0000, 400, 399);
        idle(3);
        chk("t5_len_err", {31'd0, len_err}, 32'd1);
        chk("t5_nwr", 32'(wr_cyc.size()), 32'd400);
        chk("t5_gap", 32'(wr_cyc[368] - wr_cyc[367]), 32'd3);

        // Reset mid-frame; s0 must win the next contention.
        c0 = wr_total;
        for (int i = 0; i < 3; i++) exp_w.push_back(32'hA500_0000 + 32'(i));
        fork
            send(0, 32'hA500_0000, 8, 7);
            begin
                do @(posedge clk); while (wr_total < c0 + 3);
                #3;
                rst_n = 1'b0;
                #1;
                chk("t6_ready", {31'd0, s0_ready}, 32'd0);
                chk("t6_wr_en", {31'd0, fifo_wr_en}, 32'd0);
                chk("t6_len_err", {31'd0, len_err}, 32'd0);
                chk("t6_frame_src", {31'd0, frame_src}, 32'd0);
                abort = 1'b1;
            end
        join
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        abort = 1'b0;
        idle(1);
        chk("t6_exp_flushed", 32'(exp_w.size()), 32'd0);
        push_frame(1'b0, 32'hA600_0000, 2);
        push_frame(1'b1, 32'hB600_0000, 2);
        fork
            send(0, 32'hA600_0000, 2, 1);
            send(1, 32'hB600_0000, 2, 1);
        join
        idle(4);

        chk("end_exp_w", 32'(exp_w.size()), 32'd0);
        chk("end_exp_f", 32'(exp_f.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/eth_fifo_wr_arb.md
# eth_fifo_wr_arb

Frame-atomic write-port arbiter for the 32-bit write side of the Ethernet TX FIFO (32-bit in, 8-bit out, 1024 words deep).

- Two 32-bit frame sources share the single FIFO write port: the sample-data path and the command-reply path.
- Arbitration is round-robin at frame boundaries, so frames never interleave in the FIFO.
- The block runs entirely in the FIFO write-clock domain. The FIFO's read side belongs to the UDP TX engine.

## Interface
Parameters:
- DATA_W, 32: word width; must equal the FIFO write width.
- MAX_WORDS, 368: maximum words per frame (1472-byte UDP payload / 4).
- CNT_W, 9: width of the per-frame word counter; must satisfy 2^CNT_W ≥ MAX_WORDS.

Ports:
- Clock and reset (already decided): one clock `clk`; reset `rst_n`, asynchronous, active-low.
- clk  in  1  write-domain clock, shared with FIFO wr_clk.
- rst_n  in  1  asynchronous active-low reset.
- s0_valid  in  1  source 0 (sample data) word valid.
- s0_data  in  DATA_W  source 0 word.
- s0_last  in  1  source 0 final word of frame.
- s0_ready  out  1  source 0 word accepted when valid&ready.
- s1_valid, s1_data, s1_last, s1_ready  same as above, for source 1 (command reply).
- fifo_wr_en  out  1  FIFO write enable.
- fifo_wr_data  out  DATA_W  FIFO write data.
- fifo_wr_full  in  1  FIFO full.
- fifo_almost_full  in  1  FIFO almost full (≤128 free words).
- frame_done  out  1  one-cycle pulse when a frame's last word is written.
- frame_src  out  1  source of the frame currently or last granted.
- len_err  out  1  sticky: a frame hit MAX_WORDS without last. Cleared only by reset.

## Operation
State machine: IDLE → XFER → GAP → IDLE.

- **IDLE**
  - All readys are 0.
  - If fifo_almost_full=0 and any s*_valid=1, grant a source and go to XFER next cycle. Clear word_cnt.
  - Grant selection: the requesting source other than last_src wins; a lone requester wins.
  - last_src resets to 1, so source 0 wins the first contention.
- **XFER**
  - Only the granted source is muxed through: s_ready = ~fifo_wr_full; fifo_wr_en = s_valid & ~fifo_wr_full; fifo_wr_data = s_data.
  - The ungranted ready is held at 0.
  - Each accepted word increments word_cnt.
  - Accepted word with last=1: go to GAP, pulse frame_done, set last_src = granted source.
  - Accepted word without last=1 when word_cnt = MAX_WORDS-1: this word is treated as last. Set len_err, go to GAP, pulse frame_done. Remaining words from the source then start a new frame at the next grant.
- **GAP**
  - One dead cycle, with all readys at 0.
  - Then go to IDLE.
- **Almost-full rule**
  - fifo_almost_full is sampled only in IDLE.
  - It never interrupts a frame in XFER; fifo_wr_full alone stalls an in-progress frame.
- **Boundaries**
  - fifo_wr_full=1 for many cycles in XFER: remain in XFER with no writes; data is held by the source.
  - Both valids asserted in the same cycle that frame_done fires: the new grant happens in IDLE, two cycles later, per round-robin.
  - A source's valid deasserts mid-frame: the grant is held indefinitely until that source's last word.

## Timing
- Grant latency: valid in IDLE → first possible write 1 cycle later (XFER entry).
- Per-word throughput: 1 word/cycle in XFER. fifo_wr_en/data/ready are combinational from state, source inputs and fifo_wr_full.
- Minimum inter-frame spacing: 2 cycles (GAP + IDLE).
- frame_done and len_err are registered, asserted the cycle after the last write.
- Reset values:
  - State = IDLE, last_src = 1, word_cnt = 0.
  - frame_done = 0, frame_src = 0, len_err = 0; all readys 0, fifo_wr_en = 0.
- Reset mid-frame returns to IDLE immediately. Partial frames already in the FIFO are not retracted; the FIFO is reset from the same reset.

## Configuration
- ARB_STAT_EN
  - Defined: adds outputs s0_frames and s1_frames (16-bit, wrapping, reset 0), incremented with each frame_done for the matching source; len_err-terminated frames are counted.
  - Undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Only s0 sends a 4-word frame, FIFO empty → 4 consecutive fifo_wr_en with matching data, frame_done once, frame_src=0.
- Both sources valid from reset, each with 3-word frames, repeated → frames alternate 0,1,0,1 with no interleaved words and a 2-cycle gap between frames.
- fifo_wr_full raised for 5 cycles mid-frame → s_ready=0 and fifo_wr_en=0 for exactly those cycles; no word lost or duplicated.
- fifo_almost_full=1 in IDLE with s1_valid=1 → no grant; grant occurs 1 cycle after almost_full drops. Almost_full rising during XFER does not stall the frame.
- s0 sends 400 words without last → frame ends after word 368, len_err=1, word 369 starts a new frame.
- rst_n pulsed low mid-frame → all outputs return to reset values asynchronously; the next frame starts cleanly with round-robin favouring s0.
